// File: rtl/demux5_reg.sv
// demux5_reg: registered 1-to-5 distributor.
// Writes data_in into one of five holding registers picked by selector. Each
// slot has a valid flag that its consumer clears with ack. Loads into a full
// slot are dropped and flagged. Every output comes straight from a flop.
module demux5_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [2:0]            selector,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [4:0]            ack,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic [DATA_WIDTH-1:0] data_out_3,
  output logic [DATA_WIDTH-1:0] data_out_4,
  output logic [4:0]            valid,
  output logic                  overflow,
  output logic                  bad_sel,
  output logic [7:0]            load_cnt
);

  localparam int unsigned NSLOT   = 5;
  localparam int unsigned CNT_W   = 8;
  localparam logic [2:0]  MAX_SEL = 3'd4;

  logic [DATA_WIDTH-1:0] slot_q [NSLOT];
  logic [NSLOT-1:0]      valid_q;
  logic                  overflow_q;
  logic                  bad_sel_q;
  logic [CNT_W-1:0]      load_cnt_q;

  logic [NSLOT-1:0]      load_hit_c;
  logic [NSLOT-1:0]      accept_c;
  logic                  drop_c;
  logic                  illegal_c;

  // Decode the selector and work out which load, if any, is accepted.
  always_comb begin
    load_hit_c = '0;
    accept_c   = '0;
    drop_c     = 1'b0;
    illegal_c  = load && (selector > MAX_SEL);
    for (int unsigned i = 0; i < NSLOT; i++) begin
      load_hit_c[i] = load && (selector == 3'(i));
      // A full slot can still take a new word if its consumer drains it now.
      accept_c[i]   = load_hit_c[i] && (!valid_q[i] || ack[i]);
    end
    drop_c = |(load_hit_c & valid_q & ~ack);
  end

  // Slot data registers; a slot only changes when its load is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        if (accept_c[i]) begin
          slot_q[i] <= data_in;
        end
      end
    end
  end

  // Valid flags: ack drains, an accepted load refills (refill wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= (valid_q & ~ack) | accept_c;
    end
  end

  // Sticky overflow; a new drop in the same cycle beats clr_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= drop_c || (overflow_q && !clr_err);
    end
  end

  // Single-cycle pulse for a load aimed at a nonexistent slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_sel_q <= 1'b0;
    end else begin
      bad_sel_q <= illegal_c;
    end
  end

  // Count of accepted loads, free-running wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt_q <= '0;
    end else if (|accept_c) begin
      load_cnt_q <= load_cnt_q + CNT_W'(1);
    end
  end

  assign data_out_0 = slot_q[0];
  assign data_out_1 = slot_q[1];
  assign data_out_2 = slot_q[2];
  assign data_out_3 = slot_q[3];
  assign data_out_4 = slot_q[4];
  assign valid      = valid_q;
  assign overflow   = overflow_q;
  assign bad_sel    = bad_sel_q;
  assign load_cnt   = load_cnt_q;

endmodule

// File: tb/tb_demux5_reg.sv
// tb_demux5_reg: vector table, hand sequences and a random run against a
// behavioural model of the distributor.
module tb_demux5_reg;

  logic        clk;
  logic        reset;
  logic        load;
  logic [2:0]  selector;
  logic [31:0] data_in;
  logic [4:0]  ack;
  logic        clr_err;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
  logic [4:0]  valid;
  logic        overflow;
  logic        bad_sel;
  logic [7:0]  load_cnt;

  int nerr = 0;
  int nchk = 0;

  demux5_reg #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .load(load), .selector(selector),
    .data_in(data_in), .ack(ack), .clr_err(clr_err),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .data_out_3(data_out_3), .data_out_4(data_out_4),
    .valid(valid), .overflow(overflow), .bad_sel(bad_sel), .load_cnt(load_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: slot contents, occupancy, flags, counter as plain integers.
  logic [31:0] m_data [5];
  bit          m_full [5];
  bit          m_ovf;
  bit          m_bad;
  int          m_cnt;

  typedef struct packed {
    logic        ld;
    logic [2:0]  sel;
    logic [31:0] din;
    logic [4:0]  ak;
    logic        clr;
    logic [4:0]  ev;
    logic        eo;
    logic        eb;
    logic [7:0]  ec;
    logic [2:0]  cs;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic ld, input logic [2:0] sel, input logic [31:0] din,
                              input logic [4:0] ak, input logic clr, input logic [4:0] ev,
                              input logic eo, input logic eb, input logic [7:0] ec,
                              input logic [2:0] cs, input logic [31:0] ed);
    vec_t v;
    v.ld = ld; v.sel = sel; v.din = din; v.ak = ak; v.clr = clr;
    v.ev = ev; v.eo = eo; v.eb = eb; v.ec = ec; v.cs = cs; v.ed = ed;
    return v;
  endfunction

  function automatic logic [31:0] dout(input int n);
    case (n)
      0:       return data_out_0;
      1:       return data_out_1;
      2:       return data_out_2;
      3:       return data_out_3;
      default: return data_out_4;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 5; n++) begin
      m_data[n] = 32'h0;
      m_full[n] = 0;
    end
    m_ovf = 0;
    m_bad = 0;
    m_cnt = 0;
  endtask

  // One clock of the spec's rules, written per slot index.
  task automatic model_step(input bit ld, input int sel, input logic [31:0] din,
                            input logic [4:0] ak, input bit clr);
    int  target;
    bit  dropped;
    target  = -1;
    dropped = 0;
    m_bad   = ld && (sel > 4);
    if (ld && sel <= 4) begin
      if (!m_full[sel] || ak[sel]) target = sel;
      else dropped = 1;
    end
    for (int n = 0; n < 5; n++) begin
      if (n == target) begin
        m_data[n] = din;
        m_full[n] = 1;
      end else if (ak[n]) begin
        m_full[n] = 0;
      end
    end
    if (target >= 0) m_cnt = (m_cnt + 1) % 256;
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  function automatic logic [4:0] m_valid();
    logic [4:0] v;
    for (int n = 0; n < 5; n++) v[n] = m_full[n];
    return v;
  endfunction

  // Apply one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic step(input logic ld, input logic [2:0] sel, input logic [31:0] din,
                      input logic [4:0] ak, input logic clr);
    load = ld; selector = sel; data_in = din; ack = ak; clr_err = clr;
    @(posedge clk);
    #1;
    model_step(ld, int'(sel), din, ak, clr);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 64'(valid), 64'(m_valid()));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".bad_sel"}, 64'(bad_sel), 64'(m_bad));
    chk({tag, ".load_cnt"}, 64'(load_cnt), 64'(m_cnt));
    for (int n = 0; n < 5; n++) chk($sformatf("%s.data_out_%0d", tag, n), 64'(dout(n)), 64'(m_data[n]));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 64'(valid), 64'h0);
    chk({tag, ".overflow"}, 64'(overflow), 64'h0);
    chk({tag, ".bad_sel"}, 64'(bad_sel), 64'h0);
    chk({tag, ".load_cnt"}, 64'(load_cnt), 64'h0);
    for (int n = 0; n < 5; n++) chk($sformatf("%s.data_out_%0d", tag, n), 64'(dout(n)), 64'h0);
  endtask

  vec_t vecs [15];

  initial begin
    vecs[0]  = mk(1, 3'd0, 32'hA0, 5'b00000, 0, 5'b00001, 0, 0, 8'd1, 3'd0, 32'hA0);
    vecs[1]  = mk(1, 3'd1, 32'hA1, 5'b00000, 0, 5'b00011, 0, 0, 8'd2, 3'd1, 32'hA1);
    vecs[2]  = mk(1, 3'd2, 32'hA2, 5'b00000, 0, 5'b00111, 0, 0, 8'd3, 3'd2, 32'hA2);
    vecs[3]  = mk(1, 3'd3, 32'hA3, 5'b00000, 0, 5'b01111, 0, 0, 8'd4, 3'd3, 32'hA3);
    vecs[4]  = mk(1, 3'd4, 32'hA4, 5'b00000, 0, 5'b11111, 0, 0, 8'd5, 3'd4, 32'hA4);
    vecs[5]  = mk(1, 3'd2, 32'hDEAD_BEEF, 5'b00000, 0, 5'b11111, 1, 0, 8'd5, 3'd2, 32'hA2);
    vecs[6]  = mk(0, 3'd2, 32'h0, 5'b00000, 1, 5'b11111, 0, 0, 8'd5, 3'd2, 32'hA2);
    vecs[7]  = mk(1, 3'd3, 32'h2, 5'b01000, 0, 5'b11111, 0, 0, 8'd6, 3'd3, 32'h2);
    vecs[8]  = mk(1, 3'd6, 32'h55, 5'b00000, 0, 5'b11111, 0, 1, 8'd6, 3'd3, 32'h2);
    vecs[9]  = mk(0, 3'd0, 32'h0, 5'b00000, 0, 5'b11111, 0, 0, 8'd6, 3'd0, 32'hA0);
    vecs[10] = mk(0, 3'd0, 32'h0, 5'b00101, 0, 5'b11010, 0, 0, 8'd6, 3'd0, 32'hA0);
    vecs[11] = mk(0, 3'd0, 32'h0, 5'b00001, 0, 5'b11010, 0, 0, 8'd6, 3'd2, 32'hA2);
    vecs[12] = mk(1, 3'd0, 32'h77, 5'b00000, 0, 5'b11011, 0, 0, 8'd7, 3'd0, 32'h77);
    vecs[13] = mk(1, 3'd1, 32'h99, 5'b00000, 1, 5'b11011, 1, 0, 8'd7, 3'd1, 32'hA1);
    vecs[14] = mk(0, 3'd0, 32'h0, 5'b11111, 1, 5'b00000, 0, 0, 8'd7, 3'd4, 32'hA4);

    reset = 1'b1; load = 0; selector = 0; data_in = 0; ack = 0; clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].ld, vecs[i].sel, vecs[i].din, vecs[i].ak, vecs[i].clr);
      chk($sformatf("vec%0d.valid", i), 64'(valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d.overflow", i), 64'(overflow), 64'(vecs[i].eo));
      chk($sformatf("vec%0d.bad_sel", i), 64'(bad_sel), 64'(vecs[i].eb));
      chk($sformatf("vec%0d.load_cnt", i), 64'(load_cnt), 64'(vecs[i].ec));
      chk($sformatf("vec%0d.data_out_%0d", i, vecs[i].cs), 64'(dout(int'(vecs[i].cs))), 64'(vecs[i].ed));
    end

    // Mid-stream async reset with valid=10101.
    step(1, 3'd0, 32'h10, 5'b00000, 0);
    step(1, 3'd2, 32'h12, 5'b00000, 0);
    step(1, 3'd4, 32'h14, 5'b00000, 0);
    chk("pre_reset.valid", 64'(valid), 64'h15);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all_zero("async_reset");
    load = 1; selector = 3'd1; data_in = 32'hFFFF_0001; ack = 0;
    @(posedge clk);
    #1;
    chk_all_zero("reset_hold");
    load = 0;
    reset = 1'b0;

    // Counter wrap: 256 accepted loads into slot 1 with a same-cycle ack.
    for (int i = 0; i < 256; i++) begin
      step(1, 3'd1, 32'(i), 5'b00010, 0);
      if (i == 254) chk("wrap.cnt255", 64'(load_cnt), 64'hFF);
    end
    chk("wrap.cnt0", 64'(load_cnt), 64'h00);
    chk("wrap.valid", 64'(valid), 64'h02);
    chk("wrap.data1", 64'(data_out_1), 64'hFF);
    chk("wrap.ovf", 64'(overflow), 64'h0);

    // bad_sel lasts exactly one cycle even with back-to-back idle.
    step(1, 3'd7, 32'h1234, 5'b00000, 0);
    chk("bad7.pulse", 64'(bad_sel), 64'h1);
    step(0, 3'd7, 32'h1234, 5'b00000, 0);
    chk("bad7.clear", 64'(bad_sel), 64'h0);
    chk_model("bad7");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ak;
      ak = 5'($urandom) & 5'($urandom);
      step(($urandom % 4) != 0, 3'($urandom % 8), $urandom, ak, ($urandom % 8) == 0);
      chk_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
